// File: rtl/gate_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : gate_pipe_unit
// Brief    : WIDTH-bit bitwise logic unit with eight gate ops, registered
//            through a STAGES-deep valid/ready pipeline. The result comes out
//            with its op code and OR/AND reductions.
//            Optional macro GATE_PIPE_STATS_EN adds a saturating 16-bit
//            count of output transfers (xfer_count).
// Revision : 1.0 - initial release
// ============================================================================
module gate_pipe_unit #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [2:0]       op_out,
  output logic             y_any,
  output logic             y_all
`ifdef GATE_PIPE_STATS_EN
  ,
  output logic [15:0]      xfer_count
`endif
);

  localparam int c_last = STAGES - 1;

  // Operation codes
  localparam logic [2:0] c_op_and  = 3'b000;
  localparam logic [2:0] c_op_or   = 3'b001;
  localparam logic [2:0] c_op_xor  = 3'b010;
  localparam logic [2:0] c_op_nand = 3'b011;
  localparam logic [2:0] c_op_nor  = 3'b100;
  localparam logic [2:0] c_op_xnor = 3'b101;
  localparam logic [2:0] c_op_nota = 3'b110;

  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_data [STAGES];
  logic [2:0]        r_op   [STAGES];

  logic              w_adv;
  logic [WIDTH-1:0]  w_result;

  // The whole pipe moves as one: it advances whenever the last stage is
  // empty or being drained, so a stall freezes bubbles as well as data.
  assign w_adv    = !r_valid[c_last] | out_ready;
  assign in_ready = w_adv;

  // Gate function evaluated on the incoming operands
  always_comb begin
    w_result = a;
    case (op)
      c_op_and:  w_result = a & b;
      c_op_or:   w_result = a | b;
      c_op_xor:  w_result = a ^ b;
      c_op_nand: w_result = ~(a & b);
      c_op_nor:  w_result = ~(a | b);
      c_op_xnor: w_result = ~(a ^ b);
      c_op_nota: w_result = ~a;
      default:   w_result = a;
    endcase
  end

  // First stage: capture operands result, op and valid (bubble if !in_valid)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid[0] <= 1'b0;
      r_data[0]  <= '0;
      r_op[0]    <= '0;
    end else if (w_adv) begin
      r_valid[0] <= in_valid;
      r_data[0]  <= w_result;
      r_op[0]    <= op;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_stage
      // Later stages copy their predecessor on each advance
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid[gi] <= 1'b0;
          r_data[gi]  <= '0;
          r_op[gi]    <= '0;
        end else if (w_adv) begin
          r_valid[gi] <= r_valid[gi-1];
          r_data[gi]  <= r_data[gi-1];
          r_op[gi]    <= r_op[gi-1];
        end
      end
    end
  endgenerate

  assign out_valid = r_valid[c_last];
  assign y         = r_data[c_last];
  assign op_out    = r_op[c_last];
  assign y_any     = |y;
  assign y_all     = &y;

`ifdef GATE_PIPE_STATS_EN
  logic [15:0] r_xfer_count;

  // Count completed output transfers, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_count <= '0;
    end else if (out_valid && out_ready && (r_xfer_count != 16'hFFFF)) begin
      r_xfer_count <= r_xfer_count + 16'd1;
    end
  end

  assign xfer_count = r_xfer_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_pipe_unit
// Brief    : Self-checking bench for gate_pipe_unit (WIDTH=8, STAGES=2).
//            Directed vectors with literal expectations plus a FIFO-order
//            reference model checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_pipe_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] op = '0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] y;
  logic [2:0] op_out;
  logic       y_any;
  logic       y_all;
`ifdef GATE_PIPE_STATS_EN
  logic [15:0] xfer_count;
`endif

  int tests = 0;
  int fails = 0;

  gate_pipe_unit #(.WIDTH(8), .STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .op_out    (op_out),
    .y_any     (y_any),
    .y_all     (y_all)
`ifdef GATE_PIPE_STATS_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Gate truth from the op table
  function automatic logic [7:0] gate_ref(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return x ^ z;
      3'd3: return ~(x & z);
      3'd4: return ~(x | z);
      3'd5: return ~(x ^ z);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  // Reference model: accepted transfers queue up in order, each output
  // transfer must match the oldest outstanding one.
  logic [10:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_y = '0;
  logic [2:0]  prev_op = '0;
  int          model_cnt = 0;

  always @(negedge clk) begin
    logic [10:0] e;
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_y", {y_all, y_any, op_out, y}, 0);
`ifdef GATE_PIPE_STATS_EN
      check("rst_xfer_count", xfer_count, 0);
`endif
      exp_q.delete();
      prev_stall = 1'b0;
      model_cnt = 0;
    end else begin
`ifdef GATE_PIPE_STATS_EN
      check("xfer_count", xfer_count, model_cnt);
`endif
      if (prev_stall) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_y", {op_out, y}, {prev_op, prev_y});
      end
      check("in_ready_rule", in_ready, (!out_valid) || out_ready);
      if (out_valid) begin
        check("y_any", y_any, (y != 8'h00));
        check("y_all", y_all, (y == 8'hFF));
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", out_valid, 0);
        end else if (out_ready) begin
          e = exp_q.pop_front();
          check("model_result", {op_out, y}, e);
          model_cnt++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back({op, gate_ref(op, a, b)});
      prev_stall = out_valid && !out_ready;
      prev_y = y;
      prev_op = op_out;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    in_valid = v; op = o; a = x; b = z;
  endtask

  // Present one operand set until accepted; out_ready is forced high
  // after the first refused attempt so the loop always ends.
  task automatic send_wait(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z, input logic rdy);
    bit acc;
    acc = 1'b0;
    drive(1'b1, o, x, z);
    out_ready = rdy;
    for (int k = 0; k < 8 && !acc; k++) begin
      #1;
      acc = in_ready;
      step();
      out_ready = 1'b1;
    end
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {out_valid, y_all, y_any, op_out, y}, 0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", in_ready, 1);
    step();

    // Test 1: single OR transfer, two edges of latency
    drive(1'b1, 3'b001, 8'h0F, 8'h33);
    step();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    check("t1_not_yet", out_valid, 0);
    step();
    check("t1_result", {out_valid, op_out, y, y_any, y_all}, {1'b1, 3'b001, 8'h3F, 1'b1, 1'b0});
    step();
    check("t1_done", out_valid, 0);

    // Test 2: back-to-back ops, no gaps
    drive(1'b1, 3'b000, 8'hF0, 8'hCC); step();
    drive(1'b1, 3'b010, 8'hF0, 8'hCC); step();
    check("t2_y0", {out_valid, y}, {1'b1, 8'hC0});
    drive(1'b1, 3'b011, 8'hF0, 8'hCC); step();
    check("t2_y1", {out_valid, y}, {1'b1, 8'h3C});
    drive(1'b1, 3'b101, 8'hF0, 8'hCC); step();
    check("t2_y2", {out_valid, y}, {1'b1, 8'h3F});
    drive(1'b0, 3'b000, 8'h00, 8'h00); step();
    check("t2_y3", {out_valid, op_out, y}, {1'b1, 3'b101, 8'hC3});
    step();
    check("t2_empty", out_valid, 0);

    // Test 3: backpressure with two in flight, junk inputs during stall
    drive(1'b1, 3'b000, 8'hAA, 8'h0F); step();
    drive(1'b1, 3'b001, 8'hAA, 8'h0F);
    out_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'(i), 8'(i * 37), 8'(i * 11));
      #1;
      check("t3_stall", {out_valid, in_ready, y}, {1'b1, 1'b0, 8'h0A});
      step();
    end
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    out_ready = 1'b1;
    step();
    check("t3_second", {out_valid, op_out, y}, {1'b1, 3'b001, 8'hAF});
    step();
    check("t3_drained", out_valid, 0);

    // Test 4: NAND of zeros, then NOT of ones
    drive(1'b1, 3'b011, 8'h00, 8'h00); step();
    drive(1'b1, 3'b110, 8'hFF, 8'h5A); step();
    check("t4_nand", {out_valid, y, y_all}, {1'b1, 8'hFF, 1'b1});
    drive(1'b0, 3'b000, 8'h00, 8'h00); step();
    check("t4_not", {out_valid, y, y_any, y_all}, {1'b1, 8'h00, 1'b0, 1'b0});
    step();

    // Sweep every op with intermittent backpressure
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 3'(i % 8), 8'h5A ^ 8'(i * 29), 8'h3C + 8'(i * 7));
      out_ready = ((i % 3) != 2);
      step();
    end
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    out_ready = 1'b1;
    repeat (4) step();

    // Test 5: asynchronous reset pulse between edges
    drive(1'b1, 3'b010, 8'h12, 8'h34); step();
    drive(1'b1, 3'b100, 8'h12, 8'h34); step();
    drive(1'b0, 3'b000, 8'h00, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_clear", {out_valid, y_all, y_any, op_out, y}, 0);
    #2 rst_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      check("t5_no_stale", out_valid, 0);
      step();
    end
    drive(1'b1, 3'b111, 8'h96, 8'h00); step();
    drive(1'b0, 3'b000, 8'h00, 8'h00); step();
    check("t5_new", {out_valid, op_out, y}, {1'b1, 3'b111, 8'h96});
    step();

`ifdef GATE_PIPE_STATS_EN
    // Test 6: transfer counter with two stalled outputs
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      send_wait(3'(i), 8'(i * 19), 8'hA5, !(i == 2 || i == 4));
    end
    out_ready = 1'b1;
    repeat (4) step();
    check("t6_count", xfer_count, 16'd7);
    rst_n = 1'b0;
    #1;
    check("t6_count_reset", xfer_count, 16'd0);
    #2 rst_n = 1'b1;
    step();
`else
    send_wait(3'b100, 8'h0F, 8'hF0, 1'b0);
    out_ready = 1'b1;
    repeat (3) step();
`endif

    // Everything accepted must have come out
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    check("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gate_pipe_unit.md
Name: gate_pipe_unit

Overview:
Parametrised successor to the single 2-input gate. A WIDTH-bit bitwise logic unit: eight selectable gate operations per transfer, registered through a STAGES-deep pipeline with valid/ready handshake on both sides. Result reductions (any/all) come out alongside the result. It is the basic-gate building block for the sequential chapters that follow, and the first gate block with a clock.

Parameters:
WIDTH, 8, operand and result bit width (1..64)
STAGES, 2, pipeline register depth = latency in cycles (1..4)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand transfer request
in_ready  output  1  unit accepts the operands this cycle
op  input  3  operation select, sampled with operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result present at last stage
out_ready  input  1  consumer accepts result this cycle
y  output  WIDTH  result
op_out  output  3  op code that produced y
y_any  output  1  OR-reduction of y
y_all  output  1  AND-reduction of y

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low (rst_n). While rst_n=0, all stage valids, data, op registers, y, op_out, y_any, y_all and out_valid are 0. in_ready is 1 once rst_n=1.
- Op encoding (bitwise on a, b):
  - 000 AND, 001 OR, 010 XOR, 011 NAND
  - 100 NOR, 101 XNOR, 110 NOT a (b ignored), 111 PASS a (b ignored)
  - All 8 codes are legal.
- Stage 1 captures f(op,a,b), op and in_valid. Each later stage captures its predecessor. The last stage drives y, op_out and out_valid.
- Advance condition: adv = !out_valid | out_ready. All stages shift together only when adv=1. When adv=0, every stage holds, including bubbles.
- in_ready = adv (combinational). An input transfer occurs when in_valid & in_ready. If in_valid=0 while adv=1, a bubble (valid=0) enters stage 1.
- Latency: a transfer accepted at edge N appears with out_valid=1 after edge N+STAGES-1 when no stall occurs. Throughput is 1 transfer per cycle when out_ready is held 1.
- Output transfer occurs when out_valid & out_ready. While out_valid=1 and out_ready=0:
  - y, op_out, y_any and y_all hold stable.
  - in_ready=0.
- y_any = |y and y_all = &y, both combinational from y. They are meaningful only when out_valid=1 and read 0 after reset.
- Simultaneous events: with a full pipe and out_ready=1, one output and one input transfer occur in the same cycle with no bubble. Ordering is strictly FIFO, with no reordering and no drop.
- Reset mid-operation: asserting rst_n low discards all in-flight transfers immediately (asynchronous). After release, no stale result is emitted.
- Operands or op changing while in_ready=0 have no effect.

Optional Feature:
GATE_PIPE_STATS_EN
- Defined: adds output port xfer_count [15:0].
  - Increments by 1 on every output transfer (out_valid & out_ready).
  - Saturates at 16'hFFFF.
  - Resets to 0 with rst_n.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
1. WIDTH=8, STAGES=2, out_ready=1. Apply op=001, a=8'h0F, b=8'h33 for one cycle → after two clock edges: out_valid=1, y=8'h3F, op_out=001, y_any=1, y_all=0.
2. Back-to-back ops 000, 010, 011, 101 with a=8'hF0, b=8'hCC, out_ready=1 → consecutive cycles give y = C0, 3C, 3F, C3 in order, with no gaps.
3. Backpressure: hold out_ready=0 with two transfers in flight → out_valid=1, in_ready=0, y frozen at the first result for 5 cycles. Raise out_ready → both results drain in order on consecutive cycles.
4. op=011, a=8'h00, b=8'h00 → y=8'hFF, y_all=1. Then op=110, a=8'hFF → y=8'h00, y_any=0, y_all=0.
5. Reset mid-operation: accept 2 transfers, pulse rst_n low for a non-edge-aligned 3 ns → outputs go 0 immediately. After release, out_valid stays 0 until a new transfer is accepted and completes.
6. With GATE_PIPE_STATS_EN defined: complete 7 transfers, stalling out_ready on 2 of them → xfer_count=7. Assert reset → xfer_count=0.
